dds_multiwave_gen: RTL
======================

Name: dds_multiwave_gen

Overview:
- Parametrised multi-waveform DDS generator: phase accumulator, programmable phase offset, four output shapes (sine LUT, square, triangle, sawtooth).
- Replaces the single-sine, fixed-width tone source feeding the FIR test chain.
- Configuration uses a valid/ready handshake. New settings are applied phase-continuously at the next accumulator wrap, so retuning never glitches mid-cycle.

Parameters:
- PHASE_W, 32, accumulator / increment / offset width
- ADDR_W, 12, sine LUT address width; LUT depth = 2^ADDR_W (ADDR_W <= PHASE_W-2)
- DATA_W, 12, output sample width, unsigned offset-binary (DATA_W <= PHASE_W-1)
- LUT_FILE, "sin.txt", hex init file for the sine ROM (full-wave, 2^ADDR_W entries)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  accumulator advance enable
- cfg_valid  in  1  configuration word valid
- cfg_ready  out  1  shadow register free; transfer occurs when cfg_valid & cfg_ready
- cfg_phase_inc  in  PHASE_W  new frequency tuning word
- cfg_phase_off  in  PHASE_W  new phase offset
- cfg_mode  in  2  new mode: 0 sine, 1 square, 2 triangle, 3 sawtooth
- wave_out  out  DATA_W  registered sample
- wave_valid  out  1  wave_out holds a sample produced from an enabled cycle
- wrap_pulse  out  1  one-cycle pulse, aligned with wave_out, for the sample following an accumulator carry-out

Behaviour:
- Reset (async, active-low):
  - acc = 0; active inc/off/mode = 0; shadow cleared; pending = 0
  - cfg_ready = 1; wave_out = 0; wave_valid = 0; wrap_pulse = 0; all pipeline regs = 0
- Accumulator:
  - When en=1: acc <= acc + inc_active, modulo 2^PHASE_W. Carry-out = wrap.
  - When en=0: acc holds.
- Phase:
  - ph = acc + off_active, modulo 2^PHASE_W, registered in pipeline stage 1.
- Stage 2 computes, from the stage-1 ph:
  - sine: ROM[ph[PHASE_W-1 -: ADDR_W]], synchronous ROM read
  - square: ph[PHASE_W-1] ? 0 : 2^DATA_W-1
  - triangle: t = ph[PHASE_W-2 -: DATA_W]; output ph[PHASE_W-1] ? ~t : t
  - sawtooth: ph[PHASE_W-1 -: DATA_W]
- Latency:
  - 2 clocks from an acc value to its wave_out.
  - wave_valid and wrap_pulse are delayed through matching 2-stage shift registers (en and carry, respectively).
- Mode pipelining: mode is carried down the pipeline with each sample, so a mode change affects only samples whose acc update occurred after the change.
- Config handshake:
  - On cfg_valid & cfg_ready: capture inc/off/mode into shadow; pending <= 1; cfg_ready <= 0 from the next cycle.
  - Commit: on the first cycle with en=1 and carry-out while pending=1, copy shadow to active and set pending <= 0 (cfg_ready returns to 1 the next cycle).
    - The add in that cycle uses the old inc.
    - The new inc applies from the following cycle.
    - acc is not cleared, so phase stays continuous.
  - If en=0 when pending becomes 1, commit on the next cycle (immediate apply while idle).
  - Config accepted in the same cycle as a wrap does not commit at that wrap; it waits for the next wrap.
  - cfg_valid while cfg_ready=0 is ignored; the master must hold.
- inc_active = 0 with en=1: acc frozen, no wraps. A pending config then never commits until en drops. This is documented behaviour, not an error.
- Reset mid-operation discards any pending config.

Optional Feature:
- Macro: DDS_QUARTER_WAVE_EN
- Defined:
  - ROM holds 2^(ADDR_W-2) entries, first quadrant only; LUT_FILE must match.
  - Address is mirrored with ph[PHASE_W-2]; the output is inverted (2^DATA_W-1-x) with ph[PHASE_W-1].
  - Mirroring adds one pipeline stage, so latency = 3 for all modes (non-sine paths padded to match).
- Undefined: full-wave ROM, latency 2.

Test Plan:
- Reset hold then release, en=0 -> wave_out=0, wave_valid=0, wrap_pulse=0, cfg_ready=1 for 20 cycles.
- Config inc=2^20, off=0, mode=0, en=1 -> acc addresses 0,1,2,...; wave_out(n+2) = ROM[n]; wrap_pulse every 4096 cycles.
- Mode 3, inc=2^24 -> wave_out steps 0,16,32,...,4080,0; wrap_pulse every 256 samples. Mode 1 same inc -> 4095 for 128 samples, then 0 for 128.
- Mode 2, inc=2^26 -> wave_out 0,128,...,3968, then 4095,3967,...; peak at sample 32.
- Running inc=2^28, new cfg inc=2^27 accepted mid-period:
  - cfg_ready=0 until the wrap; second cfg_valid ignored.
  - After the wrap, acc steps by 2^27, starting from the post-wrap value (no reset to 0).
  - cfg_ready=1 one cycle later.
- Pending config, then reset asserted mid-stream -> all outputs 0 immediately (async). After release, active inc=0 and pending cleared.

Source files
------------

// File: rtl/dds_multiwave_gen.sv
// -----------------------------------------------------------------------------
// dds_multiwave_gen
//
// Multi-waveform direct digital synthesis tone source. A phase accumulator
// advances by the active tuning word while en is high. A programmable phase
// offset is added in stage 1, and stage 2 shapes the phase into one of four
// offset-binary waveforms: sine ROM, square, triangle or sawtooth.
//
// New settings arrive over a valid/ready handshake into a shadow register.
// They take effect at the next accumulator wrap, or at once while en is low,
// so a retune never cuts a waveform period short.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous reset, active low
//   en             in   accumulator advance enable
//   cfg_valid      in   configuration word valid
//   cfg_ready      out  shadow register free (transfer on cfg_valid & cfg_ready)
//   cfg_phase_inc  in   new frequency tuning word   [PHASE_W]
//   cfg_phase_off  in   new phase offset            [PHASE_W]
//   cfg_mode       in   0 sine, 1 square, 2 triangle, 3 sawtooth
//   wave_out       out  registered sample           [DATA_W]
//   wave_valid     out  wave_out came from an enabled accumulator cycle
//   wrap_pulse     out  marks the first sample after an accumulator carry-out
//
// Build option
//   DDS_QUARTER_WAVE_EN : quarter-wave ROM with address mirroring and output
//                         inversion; adds one pipeline stage (latency 3).
//                         Undefined: full-wave ROM, latency 2.
//
// The sine table is generated at elaboration from a closed-form sine:
// round(H + H*sin(2*pi*i/2^ADDR_W)), with H = (2^DATA_W-1)/2. LUT_FILE names
// the matching hex image for flows that preload block RAM from a file.
// -----------------------------------------------------------------------------
module dds_multiwave_gen #(
    parameter int PHASE_W  = 32,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 12,
    parameter     LUT_FILE = "sin.txt"
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_phase_inc,
    input  logic [PHASE_W-1:0] cfg_phase_off,
    input  logic [1:0]         cfg_mode,
    output logic [DATA_W-1:0]  wave_out,
    output logic               wave_valid,
    output logic               wrap_pulse
);

`ifdef DDS_QUARTER_WAVE_EN
    localparam int ROM_AW = ADDR_W - 2;
`else
    localparam int ROM_AW = ADDR_W;
`endif
    localparam int  ROM_DEPTH = 1 << ROM_AW;
    localparam real PI        = 3.14159265358979323846;
    localparam real HALF_FS   = real'((1 << DATA_W) - 1) / 2.0;
    localparam int  unused_lut_file_w = $bits(LUT_FILE);

    // Rounded offset-binary sine code for ROM entry idx.
    function automatic logic [DATA_W-1:0] sine_entry(input int idx);
        real angle;
        int  code;
`ifdef DDS_QUARTER_WAVE_EN
        // Half-entry phase shift keeps the quadrant symmetric under mirroring.
        angle = 2.0 * PI * (real'(idx) + 0.5) / real'(1 << ADDR_W);
`else
        angle = 2.0 * PI * real'(idx) / real'(1 << ADDR_W);
`endif
        code = $rtoi(HALF_FS + HALF_FS * $sin(angle) + 0.5);
        return DATA_W'(code);
    endfunction

    logic [DATA_W-1:0] rom [ROM_DEPTH];
    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        assign rom[gi] = sine_entry(gi);
    end

    // Control state: accumulator, active and shadow configuration.
    logic [PHASE_W-1:0] acc_q, acc_d, inc_q, inc_d, off_q, off_d;
    logic [PHASE_W-1:0] sh_inc_q, sh_inc_d, sh_off_q, sh_off_d;
    logic [1:0]         mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic               pend_q, pend_d, wrapped_q, wrapped_d;
    logic [PHASE_W:0]   sum;
    logic               carry, accept, commit;

    assign sum       = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry     = sum[PHASE_W];
    assign accept    = cfg_valid & ~pend_q;
    // Commit at an enabled wrap, or immediately while the accumulator is idle.
    assign commit    = pend_q & (~en | carry);
    assign cfg_ready = ~pend_q;

    always_comb begin
        acc_d     = acc_q;
        wrapped_d = wrapped_q;
        inc_d     = inc_q;
        off_d     = off_q;
        mode_d    = mode_q;
        sh_inc_d  = sh_inc_q;
        sh_off_d  = sh_off_q;
        sh_mode_d = sh_mode_q;
        pend_d    = pend_q;
        if (en) begin
            acc_d     = sum[PHASE_W-1:0];
            // Held until an enabled sample carries it, so the pulse is never lost.
            wrapped_d = carry;
        end
        if (commit) begin
            inc_d  = sh_inc_q;
            off_d  = sh_off_q;
            mode_d = sh_mode_q;
            pend_d = 1'b0;
        end
        if (accept) begin
            sh_inc_d  = cfg_phase_inc;
            sh_off_d  = cfg_phase_off;
            sh_mode_d = cfg_mode;
            pend_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            wrapped_q <= 1'b0;
            inc_q     <= '0;
            off_q     <= '0;
            mode_q    <= '0;
            sh_inc_q  <= '0;
            sh_off_q  <= '0;
            sh_mode_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            wrapped_q <= wrapped_d;
            inc_q     <= inc_d;
            off_q     <= off_d;
            mode_q    <= mode_d;
            sh_inc_q  <= sh_inc_d;
            sh_off_q  <= sh_off_d;
            sh_mode_q <= sh_mode_d;
            pend_q    <= pend_d;
        end
    end

    // ---- Stage 1: phase = acc + offset; data only advances on enabled cycles
    logic [PHASE_W-1:0] ph_p1;
    logic [1:0]         mode_p1;
    logic               vld_p1, wrap_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_p1   <= '0;
            mode_p1 <= '0;
            vld_p1  <= 1'b0;
            wrap_p1 <= 1'b0;
        end else begin
            vld_p1  <= en;
            wrap_p1 <= en & wrapped_q;
            if (en) begin
                ph_p1   <= acc_q + off_q;
                mode_p1 <= mode_q;
            end
        end
    end

    logic unused_ph_p1;
    assign unused_ph_p1 = ^ph_p1;

    logic [DATA_W-1:0] tri_p1, shape_p1;

    always_comb begin
        tri_p1 = ph_p1[PHASE_W-2 -: DATA_W];
        case (mode_p1)
            2'd1:    shape_p1 = ph_p1[PHASE_W-1] ? '0 : '1;
            2'd2:    shape_p1 = ph_p1[PHASE_W-1] ? ~tri_p1 : tri_p1;
            2'd3:    shape_p1 = ph_p1[PHASE_W-1 -: DATA_W];
`ifdef DDS_QUARTER_WAVE_EN
            default: shape_p1 = '0;
`else
            default: shape_p1 = rom[ph_p1[PHASE_W-1 -: ADDR_W]];
`endif
        endcase
    end

    logic [DATA_W-1:0] wave_q;

`ifdef DDS_QUARTER_WAVE_EN
    // ---- Stage 2: mirror the quadrant address, pad the non-sine shapes
    logic [ROM_AW-1:0] qaddr_p1, qaddr_p2;
    logic [DATA_W-1:0] shape_p2;
    logic              neg_p2, sine_p2, vld_p2, wrap_p2, vld_p3, wrap_p3;

    assign qaddr_p1 = ph_p1[PHASE_W-2] ? ~ph_p1[PHASE_W-3 -: ROM_AW]
                                       :  ph_p1[PHASE_W-3 -: ROM_AW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qaddr_p2 <= '0;
            shape_p2 <= '0;
            neg_p2   <= 1'b0;
            sine_p2  <= 1'b0;
            vld_p2   <= 1'b0;
            wrap_p2  <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            wrap_p2 <= wrap_p1;
            if (vld_p1) begin
                qaddr_p2 <= qaddr_p1;
                shape_p2 <= shape_p1;
                neg_p2   <= ph_p1[PHASE_W-1];
                sine_p2  <= (mode_p1 == 2'd0);
            end
        end
    end

    // ---- Stage 3: ROM read, negative half-wave inverted about mid-scale
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wave_q  <= '0;
            vld_p3  <= 1'b0;
            wrap_p3 <= 1'b0;
        end else begin
            vld_p3  <= vld_p2;
            wrap_p3 <= wrap_p2;
            if (vld_p2) begin
                if (sine_p2) wave_q <= neg_p2 ? ~rom[qaddr_p2] : rom[qaddr_p2];
                else         wave_q <= shape_p2;
            end
        end
    end

    assign wave_valid = vld_p3;
    assign wrap_pulse = wrap_p3;
`else
    // ---- Stage 2: registered shape; sine is a synchronous ROM read
    logic vld_p2, wrap_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wave_q  <= '0;
            vld_p2  <= 1'b0;
            wrap_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            wrap_p2 <= wrap_p1;
            if (vld_p1) wave_q <= shape_p1;
        end
    end

    assign wave_valid = vld_p2;
    assign wrap_pulse = wrap_p2;
`endif

    assign wave_out = wave_q;

endmodule
